// File: rtl/router_port_reader_if.sv
// router_port_reader_if: FIFO-side and client-side signals of the router port reader.
interface router_port_reader_if #(
    parameter int CNT_W = 8
);
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             fifo_read_enb;
    logic             soft_reset;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             rx_sop;
    logic             rx_eop;
    logic             rx_err;
    logic             busy;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] err_cnt;
    modport master (
        input  fifo_empty, fifo_data, rx_ready,
        output fifo_read_enb, soft_reset, rx_data, rx_valid, rx_sop, rx_eop, rx_err, busy, pkt_cnt, err_cnt
    );
    modport slave (
        output fifo_empty, fifo_data, rx_ready,
        input  fifo_read_enb, soft_reset, rx_data, rx_valid, rx_sop, rx_eop, rx_err, busy, pkt_cnt, err_cnt
    );
endinterface

// File: rtl/router_port_reader.sv
// router_port_reader: drains a router output FIFO, deframes packets, checks parity
// and streams bytes to a valid/ready client; a stall watchdog requests a FIFO flush.
module router_port_reader #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 8
) (
    input logic                  clock,
    input logic                  resetn,
    router_port_reader_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT);
    typedef enum logic [1:0] {S_HDR, S_PAY, S_PAR} state_t;
    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } entry_t;
    state_t          state;
    entry_t          ent [2];
    entry_t          in_ent;
    logic [1:0]      occ;
    logic            rd_pending;
    logic [7:0]      acc;
    logic [5:0]      rem;
    logic [WD_W-1:0] wd;
    logic            pop;
    logic            stall;
    logic            timeout;
    logic [2:0]      level;
    logic            wr_idx;
    always_comb begin
        pop     = bus.rx_valid & bus.rx_ready;
        stall   = bus.rx_valid & ~bus.rx_ready;
        timeout = stall & (wd == WD_W'(TIMEOUT - 1));
        level   = {1'b0, occ} + {2'b0, rd_pending} - {2'b0, pop};
        wr_idx  = (occ == 2'd2) | ((occ == 2'd1) & ~pop);
        in_ent  = {bus.fifo_data, state == S_HDR, state == S_PAR, (state == S_PAR) && (bus.fifo_data != acc)};
    end
    // Occupancy counts the in-flight byte so a read is never issued without a free slot.
    assign bus.fifo_read_enb = resetn & ~bus.fifo_empty & ~bus.soft_reset & (level < 3'd2);
    assign bus.rx_valid      = occ != 2'd0;
    assign bus.rx_data       = ent[0].data;
    assign bus.rx_sop        = bus.rx_valid & ent[0].sop;
    assign bus.rx_eop        = bus.rx_valid & ent[0].eop;
    assign bus.rx_err        = bus.rx_valid & ent[0].err;
    assign bus.busy          = (state != S_HDR) | bus.rx_valid | rd_pending;
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state          <= S_HDR;
            ent[0]         <= '0;
            ent[1]         <= '0;
            occ            <= '0;
            rd_pending     <= 1'b0;
            acc            <= '0;
            rem            <= '0;
            wd             <= '0;
            bus.soft_reset <= 1'b0;
            bus.pkt_cnt    <= '0;
            bus.err_cnt    <= '0;
        end else begin
            bus.soft_reset <= timeout;
            wd             <= (stall && !timeout) ? wd + WD_W'(1) : '0;
            rd_pending     <= bus.fifo_read_enb & ~timeout;
            if (timeout) begin
                occ   <= '0;
                state <= S_HDR;
            end else begin
                occ <= occ + {1'b0, rd_pending} - {1'b0, pop};
                if (pop)
                    ent[0] <= ent[1];
                if (rd_pending) begin
                    ent[wr_idx] <= in_ent;
                    case (state)
                        S_HDR: begin
                            acc   <= bus.fifo_data;
                            rem   <= bus.fifo_data[7:2];
                            state <= (bus.fifo_data[7:2] == 6'd0) ? S_PAR : S_PAY;
                        end
                        S_PAY: begin
                            acc   <= acc ^ bus.fifo_data;
                            rem   <= rem - 6'd1;
                            state <= (rem == 6'd1) ? S_PAR : S_PAY;
                        end
                        default: begin
                            state       <= S_HDR;
                            bus.pkt_cnt <= bus.pkt_cnt + CNT_W'(~&bus.pkt_cnt);
                            bus.err_cnt <= bus.err_cnt + CNT_W'(in_ent.err & ~&bus.err_cnt);
                        end
                    endcase
                end
            end
        end
    end
endmodule
